bullcow_game_param: RTL and testbench
=====================================

# bullcow_game_param

Parametrised two-player Bulls & Cows game controller. It extends the fixed 4-digit game core to N-digit secrets, any base up to 2^DIGIT_W, an optional turn limit ending in a draw, saturating scores, and explicit valid/invalid entry pulses. It sits between the debounced switch/enter front end and the display/score driver. All game logic is single-clock with registered outputs.

## Interface
- DIGITS, 4, number of digits per secret/guess (2..8)
- DIGIT_W, 4, bits per digit
- BASE, 10, digits valid in range 0..BASE-1 (BASE ≤ 2^DIGIT_W, BASE ≥ DIGITS)
- MAX_TURNS, 0, total valid guesses before a draw; 0 = unlimited
- PTS_W, 8, score counter width
- CNT_W, derived $clog2(DIGITS+1), bull/cow counter width
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enter  in  1  confirm button (debounced, level)
- sw  in  DIGITS*DIGIT_W  digit entry; digit k = sw[k*DIGIT_W +: DIGIT_W]
- game_state  out  3  current FSM state encoding
- bull_count  out  CNT_W  bulls of last scored guess
- cow_count  out  CNT_W  cows of last scored guess
- score_valid  out  1  level; bull/cow outputs hold a scored guess
- entry_ok  out  1  one-cycle pulse; entry accepted
- entry_err  out  1  one-cycle pulse; entry rejected
- turn_count  out  8  valid guesses in the current game
- winner  out  2  00 none, 01 J1, 10 J2, 11 draw
- j1_points  out  PTS_W  J1 wins
- j2_points  out  PTS_W  J2 wins

## Operation
- Event = rising edge of enter: enter==1 && prev_enter==0. prev_enter is registered every cycle. Holding enter produces exactly one event.
- valid: all DIGITS digits < BASE and pairwise distinct. Evaluated combinationally on live sw in the event cycle.
- States: J1_SETUP=000, J2_SETUP=001, J1_GUESS=010, J2_GUESS=011, END_GAME=111. Other encodings go to J1_SETUP on the next clock.
- J1_SETUP / J2_SETUP:
  - valid event → store sw into secret1 / secret2, pulse entry_ok, advance to J2_SETUP / J1_GUESS.
  - invalid event → pulse entry_err, stay in state.
  - A J1_SETUP event clears score_valid, bull_count, cow_count, turn_count and winner.
- J1_GUESS checks against secret2; J2_GUESS checks against secret1.
  - invalid event → entry_err, no other change.
  - valid event →
    - bulls = count of i with g[i]==s[i].
    - cows = count of i with g[i]!=s[i] and some j≠i with g[i]==s[j].
    - Both are computed combinationally from the live guess, not from a previous register.
    - Register bulls and cows, set score_valid=1, pulse entry_ok, turn_count+1 (saturating at 255).
- Guess outcome, first match wins:
  - bulls==DIGITS → END_GAME; winner = 01 if J1 guessed, 10 if J2 guessed. The winner's points increment in the same clock, saturating at all-ones.
  - MAX_TURNS≠0 and the new turn_count==MAX_TURNS → END_GAME, winner=11, no points change.
  - Otherwise → the other player's GUESS state.
- END_GAME: outputs hold. Next event → J1_SETUP with entry_ok pulse; sw ignored.
- Secrets are never output.

## Timing
- Reset (asynchronous): state=J1_SETUP, prev_enter=0, secrets=0, and all outputs 0 (bull_count, cow_count, score_valid, entry_ok, entry_err, turn_count, winner, j1_points, j2_points).
- Latency: all state and output updates occur on the first clock edge after the event cycle (1 cycle). entry_ok/entry_err are high for exactly that one cycle.
- The winning guess scores (bull_count=DIGITS) and updates winner/points on the same edge as entry to END_GAME.
- Reset asserted mid-game aborts immediately and also clears points.
- An enter rising edge coincident with reset deassertion is not an event: prev_enter must see enter low first.

## Test plan
- Setup: reset, sw=16'h1234 event, then sw=16'h5678 event → game_state 000→001→010, two entry_ok pulses, score_valid=0.
- Scoring: J1 guesses 16'h8765 → bull=0, cow=4, state 011, turn_count=1. J2 guesses 16'h1243 → bull=2, cow=2, state 010, turn_count=2.
- Win: J1 guesses 16'h5678 → bull=4, state 111, winner=01, j1_points=1. Next event → state 000, winner=00, turn_count=0, score_valid=0.
- Invalid entries: sw=16'h1123 (repeat) and 16'h12A4 (digit ≥ BASE) in J1_SETUP and J2_GUESS → entry_err pulse, state, counts and turn_count unchanged.
- Draw: MAX_TURNS=4, four non-winning valid guesses → state 111, winner=11, points unchanged. Enter held high 20 cycles → only one event.
- Saturation/params: PTS_W=2 with 4 J2 wins → j2_points=3. DIGITS=6, BASE=16 build: secret 24'h0ABCDE, guess 24'hEDCBA0 → bull=0, cow=6. Reset mid-J2_GUESS → all outputs 0, state 000.

Source files
------------

// File: rtl/bullcow_game_param.sv
// Parametrised two-player Bulls & Cows controller: N-digit secrets,
// base-limited digits, optional turn limit (draw) and saturating scores.
module bullcow_game_param #(
    parameter int  DIGITS    = 4,
    parameter int  DIGIT_W   = 4,
    parameter int  BASE      = 10,
    parameter int  MAX_TURNS = 0,
    parameter int  PTS_W     = 8,
    localparam int CNT_W     = $clog2(DIGITS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [DIGITS*DIGIT_W-1:0] sw,
    output logic [2:0]                game_state,
    output logic [CNT_W-1:0]          bull_count,
    output logic [CNT_W-1:0]          cow_count,
    output logic                      score_valid,
    output logic                      entry_ok,
    output logic                      entry_err,
    output logic [7:0]                turn_count,
    output logic [1:0]                winner,
    output logic [PTS_W-1:0]          j1_points,
    output logic [PTS_W-1:0]          j2_points
);
    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } state_t;

    localparam int               SW_W   = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W:0] BASE_V = (DIGIT_W + 1)'(BASE);
    localparam logic [7:0]       MAX_V  = 8'(MAX_TURNS);

    state_t             state;
    logic               prev_enter;
    logic               armed;
    logic [SW_W-1:0]    secret1;
    logic [SW_W-1:0]    secret2;
    logic [SW_W-1:0]    secret;
    logic [DIGIT_W-1:0] g [DIGITS];
    logic [DIGIT_W-1:0] s [DIGITS];
    logic               enter_evt;
    logic               valid;
    logic               hit;
    logic               win;
    logic [CNT_W-1:0]   bulls;
    logic [CNT_W-1:0]   cows;
    logic [7:0]         turn_next;

    // armed stays low until enter has been seen low once after reset
    assign enter_evt  = enter & ~prev_enter & armed;
    assign game_state = state;
    assign secret     = (state == J1_GUESS) ? secret2 : secret1;
    assign turn_next  = (turn_count == 8'hFF) ? turn_count
                                              : turn_count + 8'd1;
    assign win        = (bulls == CNT_W'(DIGITS));

    always_comb begin
        valid = 1'b1;
        bulls = '0;
        cows  = '0;
        hit   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            g[k] = sw[k*DIGIT_W +: DIGIT_W];
            s[k] = secret[k*DIGIT_W +: DIGIT_W];
        end
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, g[i]} >= BASE_V)
                valid = 1'b0;
            for (int j = i + 1; j < DIGITS; j++)
                if (g[i] == g[j])
                    valid = 1'b0;
            if (g[i] == s[i])
                bulls = bulls + CNT_W'(1);
            hit = 1'b0;
            for (int j = 0; j < DIGITS; j++)
                if (j != i && g[i] == s[j])
                    hit = 1'b1;
            if (g[i] != s[i] && hit)
                cows = cows + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= J1_SETUP;
            prev_enter  <= 1'b0;
            armed       <= 1'b0;
            secret1     <= '0;
            secret2     <= '0;
            bull_count  <= '0;
            cow_count   <= '0;
            score_valid <= 1'b0;
            entry_ok    <= 1'b0;
            entry_err   <= 1'b0;
            turn_count  <= '0;
            winner      <= '0;
            j1_points   <= '0;
            j2_points   <= '0;
        end else begin
            prev_enter <= enter;
            armed      <= armed | ~enter;
            entry_ok   <= 1'b0;
            entry_err  <= 1'b0;
            case (state)
                J1_SETUP, J2_SETUP: begin
                    if (enter_evt) begin
                        if (state == J1_SETUP) begin
                            bull_count  <= '0;
                            cow_count   <= '0;
                            score_valid <= 1'b0;
                            turn_count  <= '0;
                            winner      <= '0;
                        end
                        if (!valid) begin
                            entry_err <= 1'b1;
                        end else if (state == J1_SETUP) begin
                            entry_ok <= 1'b1;
                            secret1  <= sw;
                            state    <= J2_SETUP;
                        end else begin
                            entry_ok <= 1'b1;
                            secret2  <= sw;
                            state    <= J1_GUESS;
                        end
                    end
                end
                J1_GUESS, J2_GUESS: begin
                    if (enter_evt && !valid) begin
                        entry_err <= 1'b1;
                    end else if (enter_evt) begin
                        bull_count  <= bulls;
                        cow_count   <= cows;
                        score_valid <= 1'b1;
                        entry_ok    <= 1'b1;
                        turn_count  <= turn_next;
                        if (win) begin
                            state <= END_GAME;
                            if (state == J1_GUESS) begin
                                winner <= 2'b01;
                                if (j1_points != '1)
                                    j1_points <= j1_points + PTS_W'(1);
                            end else begin
                                winner <= 2'b10;
                                if (j2_points != '1)
                                    j2_points <= j2_points + PTS_W'(1);
                            end
                        end else if (MAX_TURNS != 0 && turn_next == MAX_V) begin
                            state  <= END_GAME;
                            winner <= 2'b11;
                        end else begin
                            state <= (state == J1_GUESS) ? J2_GUESS : J1_GUESS;
                        end
                    end
                end
                END_GAME: begin
                    if (enter_evt) begin
                        state       <= J1_SETUP;
                        entry_ok    <= 1'b1;
                        bull_count  <= '0;
                        cow_count   <= '0;
                        score_valid <= 1'b0;
                        turn_count  <= '0;
                        winner      <= '0;
                    end
                end
                default: state <= J1_SETUP;
            endcase
        end
    end
endmodule

// File: tb/tb_bullcow_game_param.sv
// Bench for bullcow_game_param: default build and a 6-digit/base-16/
// 4-turn/2-bit-score build, both against a set-based reference model.
module tb_bullcow_game_param;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enter_a = 1'b0;
    logic        enter_b = 1'b0;
    logic [15:0] sw_a = '0;
    logic [23:0] sw_b = '0;

    logic [2:0] a_state, a_bull, a_cow;
    logic       a_sv, a_ok, a_err;
    logic [7:0] a_tc, a_p1, a_p2;
    logic [1:0] a_win;

    logic [2:0] b_state, b_bull, b_cow;
    logic       b_sv, b_ok, b_err;
    logic [7:0] b_tc;
    logic [1:0] b_win, b_p1, b_p2;

    always #5 clock = ~clock;

    bullcow_game_param dut_a (
        .clock(clock), .reset(reset), .enter(enter_a), .sw(sw_a),
        .game_state(a_state), .bull_count(a_bull), .cow_count(a_cow),
        .score_valid(a_sv), .entry_ok(a_ok), .entry_err(a_err),
        .turn_count(a_tc), .winner(a_win),
        .j1_points(a_p1), .j2_points(a_p2)
    );

    bullcow_game_param #(
        .DIGITS(6), .DIGIT_W(4), .BASE(16), .MAX_TURNS(4), .PTS_W(2)
    ) dut_b (
        .clock(clock), .reset(reset), .enter(enter_b), .sw(sw_b),
        .game_state(b_state), .bull_count(b_bull), .cow_count(b_cow),
        .score_valid(b_sv), .entry_ok(b_ok), .entry_err(b_err),
        .turn_count(b_tc), .winner(b_win),
        .j1_points(b_p1), .j2_points(b_p2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int sel = 0;

    int m_digits, m_base, m_max, m_ptsmax;
    int ms, mb, mc, msv, mok, merr, mtc, mwin, mp1, mp2;
    int sec1 [8];
    int sec2 [8];

    task automatic check(input string tag, input logic [31:0] got,
                         input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        if (sel == 0) begin
            check({tag, ".state"}, 32'(a_state), ms);
            check({tag, ".bull"},  32'(a_bull),  mb);
            check({tag, ".cow"},   32'(a_cow),   mc);
            check({tag, ".sv"},    32'(a_sv),    msv);
            check({tag, ".ok"},    32'(a_ok),    mok);
            check({tag, ".err"},   32'(a_err),   merr);
            check({tag, ".turn"},  32'(a_tc),    mtc);
            check({tag, ".win"},   32'(a_win),   mwin);
            check({tag, ".p1"},    32'(a_p1),    mp1);
            check({tag, ".p2"},    32'(a_p2),    mp2);
        end else begin
            check({tag, ".state"}, 32'(b_state), ms);
            check({tag, ".bull"},  32'(b_bull),  mb);
            check({tag, ".cow"},   32'(b_cow),   mc);
            check({tag, ".sv"},    32'(b_sv),    msv);
            check({tag, ".ok"},    32'(b_ok),    mok);
            check({tag, ".err"},   32'(b_err),   merr);
            check({tag, ".turn"},  32'(b_tc),    mtc);
            check({tag, ".win"},   32'(b_win),   mwin);
            check({tag, ".p1"},    32'(b_p1),    mp1);
            check({tag, ".p2"},    32'(b_p2),    mp2);
        end
    endtask

    task automatic model_reset();
        ms = 0; mb = 0; mc = 0; msv = 0; mok = 0; merr = 0;
        mtc = 0; mwin = 0; mp1 = 0; mp2 = 0;
        for (int k = 0; k < 8; k++) begin
            sec1[k] = 0;
            sec2[k] = 0;
        end
    endtask

    task automatic model_idle();
        mok = 0;
        merr = 0;
    endtask

    task automatic clear_round();
        mb = 0; mc = 0; msv = 0; mtc = 0; mwin = 0;
    endtask

    // Cows = shared digit values minus exact-position matches
    task automatic model_event(input logic [31:0] v);
        int d [8];
        bit seen [16];
        bit inset [16];
        bit ok;
        int same, common;
        ok = 1;
        for (int k = 0; k < 16; k++) begin
            seen[k] = 0;
            inset[k] = 0;
        end
        for (int k = 0; k < m_digits; k++) begin
            d[k] = int'((v >> (4 * k)) & 32'hF);
            if (d[k] >= m_base || seen[d[k]]) ok = 0;
            seen[d[k]] = 1;
        end
        mok = 0;
        merr = 0;
        case (ms)
            0: begin
                clear_round();
                if (ok) begin
                    for (int k = 0; k < m_digits; k++) sec1[k] = d[k];
                    ms = 1; mok = 1;
                end else merr = 1;
            end
            1: begin
                if (ok) begin
                    for (int k = 0; k < m_digits; k++) sec2[k] = d[k];
                    ms = 2; mok = 1;
                end else merr = 1;
            end
            2, 3: begin
                if (!ok) merr = 1;
                else begin
                    same = 0;
                    common = 0;
                    for (int k = 0; k < m_digits; k++) begin
                        int t;
                        t = (ms == 2) ? sec2[k] : sec1[k];
                        inset[t] = 1;
                        if (t == d[k]) same++;
                    end
                    for (int k = 0; k < m_digits; k++)
                        if (inset[d[k]]) common++;
                    mb = same;
                    mc = common - same;
                    msv = 1;
                    mok = 1;
                    mtc = (mtc < 255) ? mtc + 1 : 255;
                    if (same == m_digits) begin
                        if (ms == 2) begin
                            mwin = 1;
                            if (mp1 < m_ptsmax) mp1++;
                        end else begin
                            mwin = 2;
                            if (mp2 < m_ptsmax) mp2++;
                        end
                        ms = 7;
                    end else if (m_max != 0 && mtc == m_max) begin
                        mwin = 3;
                        ms = 7;
                    end else ms = (ms == 2) ? 3 : 2;
                end
            end
            default: begin
                clear_round();
                ms = 0;
                mok = 1;
            end
        endcase
    endtask

    function automatic logic [31:0] gen_valid();
        int pool [16];
        logic [31:0] v;
        for (int i = 0; i < 16; i++) pool[i] = i;
        for (int i = m_base - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        v = '0;
        for (int k = 0; k < m_digits; k++)
            v = v | (32'(pool[k]) << (4 * k));
        return v;
    endfunction

    function automatic logic [31:0] pack_opp();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < m_digits; k++)
            v = v | (32'((ms == 2) ? sec2[k] : sec1[k]) << (4 * k));
        return v;
    endfunction

    task automatic press(input logic [31:0] v, input int hold);
        if (sel == 0) begin
            sw_a = v[15:0];
            enter_a = 1'b1;
        end else begin
            sw_b = v[23:0];
            enter_b = 1'b1;
        end
        @(posedge clock); #1;
        model_event(v);
        check_all("evt");
        for (int h = 1; h < hold; h++) begin
            @(posedge clock); #1;
            model_idle();
            check_all("hold");
        end
        enter_a = 1'b0;
        enter_b = 1'b0;
        @(posedge clock); #1;
        model_idle();
        check_all("idle");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        model_idle();
        check_all("post_rst");
    endtask

    task automatic random_run(input int n);
        logic [31:0] v;
        logic [31:0] mask;
        int r;
        mask = (m_digits == 6) ? 32'hFFFFFF : 32'hFFFF;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) v = $urandom & mask;
            else if (r < 5 && (ms == 2 || ms == 3)) v = pack_opp();
            else v = gen_valid();
            press(v, (r == 9) ? 3 : 1);
        end
    endtask

    initial begin
        sel = 0;
        m_digits = 4; m_base = 10; m_max = 0; m_ptsmax = 255;
        #2;
        do_reset();

        // enter rising together with reset release must be ignored
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        enter_a = 1'b1;
        sw_a = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            model_idle();
            check_all("coinc");
        end
        enter_a = 1'b0;
        @(posedge clock); #1;
        check_all("coinc_low");

        press(32'h1234, 1);
        press(32'h5678, 1);
        press(32'h8765, 1);
        press(32'h1243, 1);
        press(32'h5678, 1);
        press(32'h0000, 1);
        press(32'h1123, 1);
        press(32'h12A4, 1);
        press(32'h1234, 1);
        press(32'h5678, 1);
        press(32'h8765, 4);
        press(32'h1123, 1);
        press(32'h12A4, 1);
        random_run(150);

        sel = 1;
        m_digits = 6; m_base = 16; m_max = 4; m_ptsmax = 3;
        do_reset();
        press(32'h123456, 1);
        press(32'h0ABCDE, 1);
        press(32'hEDCBA0, 1);
        press(32'h654321, 1);
        press(32'h789ABC, 1);
        press(32'h213456, 20);
        press(32'h000000, 1);
        for (int g = 0; g < 4; g++) begin
            press(32'h123456, 1);
            press(32'h0ABCDE, 1);
            press(32'h789ABC, 1);
            press(32'h123456, 1);
            press(32'h000000, 1);
        end
        press(32'h123456, 1);
        press(32'h0ABCDE, 1);
        press(32'h789ABC, 1);
        do_reset();
        random_run(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
